// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - show-ahead read port of the UART receive buffer
interface uart_rx_fifo_if #(
    parameter int CNT_W = 4
) ();
    logic [7:0]       o_data;
    logic             o_valid;
    logic             i_ready;
    logic [CNT_W-1:0] o_count;

    modport master (output o_data, output o_valid, output o_count, input i_ready);
    modport slave  (input o_data, input o_valid, input o_count, output i_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with byte buffer; UART_RX_FIFO_EN selects DEPTH-entry FIFO over holding register
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int DEPTH       = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_uart_rx,
    uart_rx_fifo_if.master  rx_if,
    output logic            o_overrun,
    output logic            o_frame_err,
    input  logic            i_clr_err
);
    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [1:0]       sync_q;
    logic             rx_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitn_q, bitn_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push, frame_set;

    logic [CW-1:0]    count_q, count_d;
    logic             full, pop, accept, overrun_set;
    logic [7:0]       head;
    logic             overrun_q, frame_err_q;

    always_ff @(posedge clk) begin
        if (!resetn) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], i_uart_rx};
    end
    assign rx_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitn_d    = bitn_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_M1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = DIV_M1;
                    bitn_d  = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = DIV_M1;
                    if (bitn_q == 3'd7) state_d = ST_STOP;
                    else                bitn_d  = bitn_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_d   = ST_BREAK;
                end
            end
            // A line held low must return high before a new start bit is accepted.
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bitn_q  <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
        end
    end

    assign pop         = rx_if.o_valid & rx_if.i_ready;
    assign accept      = push & (~full | pop);
    assign overrun_set = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;

    assign full = (count_q == CW'(DEPTH));
    assign head = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_q] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (accept) wr_q <= wr_q + 1'b1;
            if (pop)    rd_q <= rd_q + 1'b1;
            count_q <= count_d;
        end
    end
`else
    logic [7:0] hold_q;

    assign full = (count_q != '0);
    assign head = hold_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_q  <= 8'd0;
            count_q <= '0;
        end else begin
            if (accept) hold_q <= shreg_q;
            count_q <= count_d;
        end
    end
`endif

    assign rx_if.o_valid = (count_q != '0);
    assign rx_if.o_data  = rx_if.o_valid ? head : 8'd0;
    assign rx_if.o_count = count_q;

    // Setting a flag takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_set | (overrun_q & ~i_clr_err);
            frame_err_q <= frame_set | (frame_err_q & ~i_clr_err);
        end
    end

    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;
endmodule
